// File: rtl/digital_clock_hms_pkg.sv
// Shared constants and BCD helpers for the HMS real-time clock.
package digital_clock_pkg;

    localparam logic [3:0] MAX_HR_TENS = 4'd2;
    localparam logic [7:0] MAX_HR      = 8'h23;
    localparam logic [3:0] MAX_MS_TENS = 4'd5;
    localparam logic [7:0] MAX_MS      = 8'h59;

    // True when hr/min/sec form a legal 24-hour BCD time.
    function automatic logic bcd_time_valid(input logic [7:0] hr,
                                            input logic [7:0] min,
                                            input logic [7:0] sec);
        return (hr[3:0]  <= 4'd9) && (min[3:0] <= 4'd9) && (sec[3:0] <= 4'd9) &&
               (hr[7:4]  <= MAX_HR_TENS) && (hr <= MAX_HR) &&
               (min[7:4] <= MAX_MS_TENS) && (sec[7:4] <= MAX_MS_TENS);
    endfunction

    // 24-hour BCD hour to {pm, 12-hour BCD hour}; 00 shows as 12.
    function automatic logic [8:0] to_12h(input logic [7:0] hr);
        logic [4:0] bin;
        logic [4:0] h;
        logic [7:0] bcd;
        bin = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
        if (bin == 5'd0)       h = 5'd12;
        else if (bin > 5'd12)  h = bin - 5'd12;
        else                   h = bin;
        bcd = (h >= 5'd10) ? {4'd1, 4'(h - 5'd10)} : {4'd0, h[3:0]};
        return {(bin >= 5'd12), bcd};
    endfunction

endpackage

// File: rtl/digital_clock_hms_if.sv
// Control, load and display signals of the HMS clock.
interface digital_clock_hms_if;
    logic       run;
    logic       mode_12h;
    logic       load;
    logic [7:0] load_hr;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       alarm_set;
    logic [7:0] alarm_hr;
    logic [7:0] alarm_min;
    logic       alarm_en;
    logic [7:0] time_hr;
    logic [7:0] time_min;
    logic [7:0] time_sec;
    logic       pm;
    logic       tick;
    logic       alarm;
    logic       load_err;

    modport master (
        output run, mode_12h, load, load_hr, load_min, load_sec,
               alarm_set, alarm_hr, alarm_min, alarm_en,
        input  time_hr, time_min, time_sec, pm, tick, alarm, load_err
    );

    modport slave (
        input  run, mode_12h, load, load_hr, load_min, load_sec,
               alarm_set, alarm_hr, alarm_min, alarm_en,
        output time_hr, time_min, time_sec, pm, tick, alarm, load_err
    );
endinterface

// File: rtl/digital_clock_hms_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX (e.g. 59 or 23), with load and carry.
module bcd_mod_counter
    import digital_clock_pkg::*;
#(
    parameter logic [7:0] MAX = MAX_MS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] value,
    output logic       carry_out
);

    assign carry_out = inc && (value == MAX);

    // Clear beats load beats increment; units 9 rolls into tens.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                value <= 8'h00;
        else if (clr)              value <= 8'h00;
        else if (ld)               value <= ld_val;
        else if (inc) begin
            if (value == MAX)            value <= 8'h00;
            else if (value[3:0] == 4'd9) value <= {value[7:4] + 4'd1, 4'd0};
            else                         value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/digital_clock_hms.sv
// BCD hh:mm:ss clock with tick divider, validated load, 12/24h display, alarm.
module digital_clock_hms
    import digital_clock_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter bit ALARM_ENABLE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    digital_clock_hms_if.slave bus
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;
    logic [7:0]    hr, min, sec;
    logic          load_valid, load_ok, load_bad;
    logic          wrap, step;
    logic          sec_co, min_co, hr_carry_unused;
    logic          tick_q, err_q;
    logic          alarm_hit, alarm_bad;
    logic [8:0]    disp12;

    assign load_valid = bcd_time_valid(bus.load_hr, bus.load_min, bus.load_sec);
    assign load_ok    = bus.load && load_valid;
    assign load_bad   = bus.load && !load_valid;
    assign wrap       = bus.run && (div == DIV_LAST);
    // An accepted load swallows a coincident advance.
    assign step       = wrap && !load_ok;

    // Divider: restarts on accepted load, holds while frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       div <= '0;
        else if (load_ok) div <= '0;
        else if (bus.run) div <= wrap ? '0 : div + DW'(1);
    end

    bcd_mod_counter #(.MAX(MAX_MS)) u_sec (
        .clock(clock), .reset(reset), .inc(step), .clr(1'b0),
        .ld(load_ok), .ld_val(bus.load_sec), .value(sec), .carry_out(sec_co)
    );

    bcd_mod_counter #(.MAX(MAX_MS)) u_min (
        .clock(clock), .reset(reset), .inc(sec_co), .clr(1'b0),
        .ld(load_ok), .ld_val(bus.load_min), .value(min), .carry_out(min_co)
    );

    bcd_mod_counter #(.MAX(MAX_HR)) u_hr (
        .clock(clock), .reset(reset), .inc(min_co), .clr(1'b0),
        .ld(load_ok), .ld_val(bus.load_hr), .value(hr), .carry_out(hr_carry_unused)
    );

    // One-cycle status pulses aligned with the updated time.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= step;
            err_q  <= load_bad || alarm_bad;
        end
    end

    generate
        if (ALARM_ENABLE) begin : g_alarm
            logic [7:0] al_hr, al_min;
            logic       set_valid;

            assign set_valid = bcd_time_valid(bus.alarm_hr, bus.alarm_min, 8'h00);
            assign alarm_bad = bus.alarm_set && !set_valid;
            // tick_q means the state just advanced, so loads and freezes never fire.
            assign alarm_hit = tick_q && bus.alarm_en && (sec == 8'h00) &&
                               (min == al_min) && (hr == al_hr);

            // Alarm target capture, rejected sets leave it untouched.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    al_hr  <= 8'h00;
                    al_min <= 8'h00;
                end else if (bus.alarm_set && set_valid) begin
                    al_hr  <= bus.alarm_hr;
                    al_min <= bus.alarm_min;
                end
            end
        end else begin : g_no_alarm
            assign alarm_bad = 1'b0;
            assign alarm_hit = 1'b0;
        end
    endgenerate

    assign disp12       = to_12h(hr);
    assign bus.time_hr  = bus.mode_12h ? disp12[7:0] : hr;
    assign bus.time_min = min;
    assign bus.time_sec = sec;
    assign bus.pm       = disp12[8];
    assign bus.tick     = tick_q;
    assign bus.alarm    = alarm_hit;
    assign bus.load_err = err_q;

endmodule

// File: tb/tb_digital_clock_hms.sv
// Bench for digital_clock_hms: vector table on a TICK_DIV=1 clock, hand
// sequences for divider spacing, freeze and async reset on a TICK_DIV=4 clock.
module tb_digital_clock_hms;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
        logic       pm;
        logic       tick;
        logic       alarm;
        logic       err;
    } obs_t;

    typedef struct {
        logic        run, mode, ld;
        logic [23:0] lt;
        logic        as;
        logic [15:0] at;
        logic        ae;
        obs_t        exp;
    } vec_t;

    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];
    obs_t exp_q[$];

    digital_clock_hms_if if1();
    digital_clock_hms_if if4();

    digital_clock_hms #(.TICK_DIV(1), .ALARM_ENABLE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .bus(if1)
    );
    digital_clock_hms #(.TICK_DIV(4), .ALARM_ENABLE(1'b1)) dut4 (
        .clock(clock), .reset(reset), .bus(if4)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(bit run, bit mode, bit ld, logic [23:0] lt,
                                bit as, logic [15:0] at, bit ae,
                                logic [23:0] et, bit epm, bit etk, bit eal, bit eer);
        vec_t v;
        v.run = run; v.mode = mode; v.ld = ld; v.lt = lt;
        v.as = as; v.at = at; v.ae = ae;
        v.exp = obs_t'({et, epm, etk, eal, eer});
        return v;
    endfunction

    function automatic obs_t obs1();
        return obs_t'({if1.time_hr, if1.time_min, if1.time_sec,
                       if1.pm, if1.tick, if1.alarm, if1.load_err});
    endfunction

    function automatic obs_t obs4();
        return obs_t'({if4.time_hr, if4.time_min, if4.time_sec,
                       if4.pm, if4.tick, if4.alarm, if4.load_err});
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (hr_min_sec_pm_tick_alarm_err)",
                      name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        if1.run = v.run; if1.mode_12h = v.mode; if1.load = v.ld;
        {if1.load_hr, if1.load_min, if1.load_sec} = v.lt;
        if1.alarm_set = v.as; {if1.alarm_hr, if1.alarm_min} = v.at;
        if1.alarm_en = v.ae;
    endtask

    task automatic idle4();
        if4.run = 1'b0; if4.mode_12h = 1'b0; if4.load = 1'b0;
        if4.load_hr = 8'h00; if4.load_min = 8'h00; if4.load_sec = 8'h00;
        if4.alarm_set = 1'b0; if4.alarm_hr = 8'h00; if4.alarm_min = 8'h00;
        if4.alarm_en = 1'b0;
    endtask

    // Edges until if4 ticks, bounded by budget.
    task automatic count_to_tick(input int budget, output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(posedge clock); #1;
            n++;
            if (if4.tick) got = 1'b1;
        end
    endtask

    initial begin
        int n;
        int total;

        apply(mk(N,N,N,24'h0,N,16'h0,N,24'h0,N,N,N,N));
        idle4();

        // Reset state in both display modes.
        @(posedge clock); #1;
        check("reset_24h", obs1(), obs_t'({24'h000000, 4'b0000}));
        check("reset_div4", obs4(), obs_t'({24'h000000, 4'b0000}));
        if1.mode_12h = 1'b1; #1;
        check("reset_12h", obs1(), obs_t'({24'h120000, 4'b0000}));
        if1.mode_12h = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        //               run mode ld  load_time   as  alarm  ae   exp_time  pm tick alm err
        vecs.push_back(mk(N, N, Y, 24'h235958, N, 16'h0000, N, 24'h235958, Y, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h235959, Y, Y, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h000000, N, Y, N, N));
        vecs.push_back(mk(N, Y, Y, 24'h130500, N, 16'h0000, N, 24'h010500, Y, N, N, N));
        vecs.push_back(mk(N, Y, Y, 24'h003000, N, 16'h0000, N, 24'h123000, N, N, N, N));
        vecs.push_back(mk(N, Y, Y, 24'h120000, N, 16'h0000, N, 24'h120000, Y, N, N, N));
        vecs.push_back(mk(N, N, Y, 24'h240000, N, 16'h0000, N, 24'h120000, Y, N, N, Y));
        vecs.push_back(mk(N, N, Y, 24'h126000, N, 16'h0000, N, 24'h120000, Y, N, N, Y));
        vecs.push_back(mk(N, N, Y, 24'h091A00, N, 16'h0000, N, 24'h120000, Y, N, N, Y));
        vecs.push_back(mk(N, N, N, 24'h000000, N, 16'h0000, N, 24'h120000, Y, N, N, N));
        vecs.push_back(mk(Y, N, Y, 24'h050607, N, 16'h0000, N, 24'h050607, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h050608, N, Y, N, N));
        vecs.push_back(mk(N, Y, Y, 24'h235958, N, 16'h0000, N, 24'h115958, Y, N, N, N));
        vecs.push_back(mk(Y, Y, N, 24'h000000, N, 16'h0000, N, 24'h115959, Y, Y, N, N));
        vecs.push_back(mk(Y, Y, N, 24'h000000, N, 16'h0000, N, 24'h120000, N, Y, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h000001, N, Y, N, N));
        vecs.push_back(mk(N, N, Y, 24'h072959, Y, 16'h0730, Y, 24'h072959, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, Y, 24'h073000, N, Y, Y, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, Y, 24'h073001, N, Y, N, N));
        vecs.push_back(mk(N, N, Y, 24'h072959, N, 16'h0000, N, 24'h072959, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h073000, N, Y, N, N));
        vecs.push_back(mk(N, N, Y, 24'h073000, N, 16'h0000, Y, 24'h073000, N, N, N, N));
        vecs.push_back(mk(N, N, N, 24'h000000, N, 16'h0000, Y, 24'h073000, N, N, N, N));
        vecs.push_back(mk(N, N, Y, 24'h072959, Y, 16'h2400, Y, 24'h072959, N, N, N, Y));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, Y, 24'h073000, N, Y, Y, N));
        vecs.push_back(mk(N, N, Y, 24'h999999, Y, 16'h0815, Y, 24'h073000, N, N, N, Y));
        vecs.push_back(mk(N, N, Y, 24'h081459, N, 16'h0000, Y, 24'h081459, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, Y, 24'h081500, N, Y, Y, N));
        vecs.push_back(mk(N, N, Y, 24'h000959, N, 16'h0000, N, 24'h000959, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h001000, N, Y, N, N));
        vecs.push_back(mk(N, N, Y, 24'h095959, N, 16'h0000, N, 24'h095959, N, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h100000, N, Y, N, N));
        vecs.push_back(mk(N, N, Y, 24'h195959, N, 16'h0000, N, 24'h195959, Y, N, N, N));
        vecs.push_back(mk(Y, N, N, 24'h000000, N, 16'h0000, N, 24'h200000, Y, Y, N, N));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), obs1(), exp_q.pop_front());
        end
        apply(mk(N,N,N,24'h0,N,16'h0,N,24'h0,N,N,N,N));

        // TICK_DIV=4: regular spacing from a cleared divider.
        if4.run = 1'b1;
        count_to_tick(20, n);
        check_int("div4_first_gap", n, 4);
        check("div4_first_tick", obs4(), obs_t'({24'h000001, 4'b0100}));
        count_to_tick(20, n);
        check_int("div4_second_gap", n, 4);
        check("div4_second_tick", obs4(), obs_t'({24'h000002, 4'b0100}));

        // Freeze for 3 cycles mid-count stretches the gap by exactly 3.
        repeat (2) begin @(posedge clock); #1; end
        if4.run = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("div4_frozen", obs4(), obs_t'({24'h000002, 4'b0000}));
        if4.run = 1'b1;
        count_to_tick(20, n);
        total = n + 5;
        check_int("div4_freeze_gap", total, 7);
        check("div4_after_freeze", obs4(), obs_t'({24'h000003, 4'b0100}));

        // Async reset between edges, then restart from 00:00:00.
        if4.load = 1'b1;
        {if4.load_hr, if4.load_min, if4.load_sec} = 24'h154217;
        @(posedge clock); #1;
        if4.load = 1'b0;
        check("div4_load", obs4(), obs_t'({24'h154217, 4'b1000}));
        repeat (2) begin @(posedge clock); #1; end
        #3 reset = 1'b0;
        #1 check("async_reset", obs4(), obs_t'({24'h000000, 4'b0000}));
        #2 reset = 1'b1;
        count_to_tick(20, n);
        check_int("post_reset_gap", n, 4);
        check("post_reset_tick", obs4(), obs_t'({24'h000001, 4'b0100}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/digital_clock_hms.md
Name: digital_clock_hms

Overview:
Parametrised BCD real-time clock. Keeps hours, minutes and seconds, and runs from a programmable clock-enable divider. Provides 12/24-hour display mode, a validated parallel load, and a one-shot alarm. Successor to the hour/minute clock; feeds the seven-segment display driver and the alarm/buzzer logic.

Parameters:
- TICK_DIV, 1, clock cycles per one-second advance (>=1); 1 = advance every enabled cycle (simulation/bench use)
- ALARM_ENABLE, 1, 0 removes alarm registers/logic; alarm output tied 0

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- run  in  1  1 = divider counts and time advances; 0 = freeze (divider held)
- mode_12h  in  1  display mode: 1 = 12-hour with pm flag, 0 = 24-hour
- load  in  1  single-cycle load strobe
- load_hr  in  8  BCD hours, always 24-hour format {tens,units}
- load_min  in  8  BCD minutes
- load_sec  in  8  BCD seconds
- alarm_set  in  1  strobe: capture alarm_hr/alarm_min (same validation as load)
- alarm_hr  in  8  BCD, 24-hour format
- alarm_min  in  8  BCD
- alarm_en  in  1  arms alarm
- time_hr  out  8  BCD display hours (mode dependent)
- time_min  out  8  BCD minutes
- time_sec  out  8  BCD seconds
- pm  out  1  1 when internal hour >= 12 (valid in both modes)
- tick  out  1  one-cycle pulse on each time advance
- alarm  out  1  one-cycle pulse on alarm match
- load_err  out  1  one-cycle pulse on rejected load or alarm_set

Behaviour:
- Internal state is always 24-hour BCD: hr 00..23, min 00..59, sec 00..59.
- Reset (asynchronous, active-low):
  - Internal time 00:00:00; divider 0; alarm registers 00:00.
  - tick, alarm and load_err are 0.
  - Display after reset: 00:00:00 with pm=0 (24h); 12:00:00 with pm=0 (12h).
- Divider: width clog2(TICK_DIV), min 1 bit.
  - While run=1: increments each cycle. At TICK_DIV-1 it wraps to 0 and the time advances on that edge.
  - While run=0: divider and time hold.
- Advance carry chain:
  - sec units 9 -> 0 carries into sec tens; sec tens 5 -> 0 carries into min units; minutes follow the same pattern into hours.
  - Hours count 00..09 -> 10..19 -> 20..23. 23 -> 00 wraps the whole clock: 23:59:59 -> 00:00:00.
  - tick is registered and asserts the cycle after the advancing edge, aligned with the new time values.
- Load:
  - Accepted only if every digit <=9, hr<=23, min tens<=5, sec tens<=5.
  - Accepted: new time visible next cycle; divider cleared to 0.
  - Rejected: time and divider unchanged; load_err=1 for one cycle.
  - Load has priority over an advance in the same cycle; that advance is dropped and no tick is produced.
- Load while run=0 is permitted.
- alarm_set: same validation rule on hr/min; a rejected alarm_set pulses load_err and leaves the alarm registers unchanged. load and alarm_set in the same cycle are handled independently, and load_err ORs both failures.
- Alarm:
  - Fires only on an advance that lands on hh:mm:00 equal to the alarm registers while alarm_en=1.
  - alarm is asserted in the same cycle as the matching tick.
  - Loading a matching time does not fire. Freezing at the match does not refire.
- 12h display conversion is combinational from internal state:
  - internal 00 -> 12
  - 01..12 -> unchanged
  - 13..23 -> hr-12, in BCD
  - pm = (internal hr >= 12)
  - Changing mode_12h changes only the display, never internal state.
- Reset mid-operation (any cycle, including during a load) wins. State returns to the reset values immediately, without waiting for a clock edge.

Decomposition:
- Package digital_clock_pkg:
  - constants MAX_HR_TENS=2, MAX_HR=8'h23, MAX_MS_TENS=5
  - function bcd_time_valid(hr, min, sec)
  - function to_12h(hr) returning {pm, bcd_hr}
- Sub-module bcd_mod_counter, parametrised by MAX:
  - inputs: inc, clr, load value
  - outputs: value, carry_out (inc & value==MAX)
  - Instantiate per field. Hours use one 8-bit instance with MAX=8'h23 and internal units/tens handling.

Test Plan:
- TICK_DIV=1, run=1, load 23:59:58 -> next two ticks show 23:59:59, 00:00:00; pm 1 -> 0.
- mode_12h=1, load 13:05:00 -> time_hr=8'h01, pm=1. Load 00:30:00 -> time_hr=8'h12, pm=0. Load 12:00:00 -> 8'h12, pm=1.
- Load 24:00:00, then 12:60:00, then 09:1A:00 -> load_err pulses each time; time unchanged. A run=1 tick coincident with a valid load -> load value wins, no tick that cycle.
- alarm_set 07:30, alarm_en=1, load 07:29:59 -> next advance shows 07:30:00 with alarm=1 for exactly one cycle. Repeat with alarm_en=0 -> no pulse. Load 07:30:00 directly -> no pulse.
- TICK_DIV=4: tick every 4th cycle. Toggle run low for 3 cycles mid-count -> tick spacing extends by exactly 3 cycles.
- Assert reset low mid-count at 15:42:17 between clock edges -> outputs 00:00:00 immediately. Release -> first tick after TICK_DIV enabled cycles shows 00:00:01.
